// File: rtl/rr_arbiter8_enc_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
interface rr_arbiter8_enc_if;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    // Requester / controller side: drives requests, observes ownership.
    modport master (
        output en,
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  en,
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8_enc.sv
// Eight-way round-robin arbiter with registered one-hot and encoded grant,
// grant hold until done/request drop, and an optional watchdog release.
module rr_arbiter8_enc #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_arbiter8_enc_if.slave   bus
);

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    // Last hold count at which the watchdog fires (unused when HOLD_MAX is 0).
    localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               gnt_vld_q, gnt_vld_d;
    logic               timeout_q, timeout_d;

    logic [IDX_W-1:0]   search_base_c;
    logic [IDX_W-1:0]   cand_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic               win_vld_c;
    logic               rel_done_c;
    logic               rel_drop_c;
    logic               rel_to_c;

    // Rotating priority search; while granting, search from the post-release pointer.
    always_comb begin
        search_base_c = (state_q == ST_GRANT) ? gnt_idx_q + IDX_W'(1) : ptr_q;
        cand_c        = '0;
        win_idx_c     = '0;
        win_vld_c     = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_c = search_base_c + IDX_W'(i);
            if (!win_vld_c && bus.req[cand_c]) begin
                win_vld_c = 1'b1;
                win_idx_c = cand_c;
            end
        end
    end

    // Release causes of the current grant.
    always_comb begin
        rel_done_c = bus.done;
        rel_drop_c = !bus.req[gnt_idx_q];
        rel_to_c   = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_vld_d  = gnt_vld_q;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.en && win_vld_c) begin
                    state_d    = ST_GRANT;
                    gnt_d      = N_REQ'(1) << win_idx_c;
                    gnt_idx_d  = win_idx_c;
                    gnt_vld_d  = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (rel_done_c || rel_drop_c || rel_to_c) begin
                    ptr_d     = gnt_idx_q + IDX_W'(1);
                    timeout_d = rel_to_c && !rel_done_c && !rel_drop_c;
                    if (bus.en && win_vld_c) begin
                        gnt_d      = N_REQ'(1) << win_idx_c;
                        gnt_idx_d  = win_idx_c;
                        gnt_vld_d  = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        state_d    = ST_IDLE;
                        gnt_d      = '0;
                        gnt_idx_d  = '0;
                        gnt_vld_d  = 1'b0;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = '0;
                gnt_idx_d  = '0;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8_enc.sv
// Randomized and directed bench for rr_arbiter8_enc against a behavioural model.
module tb_rr_arbiter8_enc;

    localparam int unsigned TB_HOLD = 4;

    logic clk;
    logic rst_n;

    rr_arbiter8_enc_if bus ();

    rr_arbiter8_enc #(
        .HOLD_MAX (TB_HOLD),
        .CNT_W    (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner (-1 when idle), rotation pointer, cycles the grant has been visible.
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_tmo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int base, input logic [7:0] r);
        for (int i = 0; i < 8; i++) begin
            if (r[(base + i) % 8]) return (base + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic [7:0] r, input logic d);
        bit by_done, by_drop, by_limit;
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            if (e && r != 8'h00) begin
                m_owner = pick(m_ptr, r);
                m_held  = 1;
            end
        end else begin
            by_done  = d;
            by_drop  = !r[m_owner];
            by_limit = (TB_HOLD != 0) && (m_held == int'(TB_HOLD));
            if (by_done || by_drop || by_limit) begin
                m_ptr = (m_owner + 1) % 8;
                m_tmo = by_limit && !by_done && !by_drop;
                if (e && r != 8'h00) begin
                    m_owner = pick(m_ptr, r);
                    m_held  = 1;
                end else begin
                    m_owner = -1;
                    m_held  = 0;
                end
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic compare_all();
        logic [7:0] eg;
        eg = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
        check("gnt", 32'(bus.gnt), 32'(eg));
        check("gnt_idx", 32'(bus.gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("gnt_vld", 32'(bus.gnt_vld), (m_owner < 0) ? 32'd0 : 32'd1);
        check("timeout", 32'(bus.timeout), 32'(m_tmo));
        check("inv_vld", 32'(bus.gnt_vld), 32'(|bus.gnt));
    endtask

    // One clock: drive inputs, advance, update model, sample 1 ns after the edge.
    task automatic cycle(input logic e, input logic [7:0] r, input logic d);
        bus.en   = e;
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_step(e, r, d);
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] cur_req;
        bus.en   = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Back-to-back release and pointer wrap.
        cycle(1'b1, 8'h81, 1'b0);
        check("tp1_first", 32'(bus.gnt), 32'h01);
        cycle(1'b1, 8'h81, 1'b1);
        check("tp1_b2b", 32'(bus.gnt_idx), 32'd7);
        cycle(1'b1, 8'h81, 1'b1);
        check("tp1_wrap", 32'(bus.gnt), 32'h01);

        // Full rotation with all requesters active.
        do_reset();
        cycle(1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 8'hFF, 1'b1);
            check("tp2_rot", 32'(bus.gnt_idx), 32'((i + 1) % 8));
        end

        // Watchdog release of a sole requester, then done on the last cycle.
        do_reset();
        cycle(1'b1, 8'h08, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h08, 1'b0);
        check("tp3_held", 32'(bus.gnt), 32'h08);
        cycle(1'b1, 8'h08, 1'b0);
        check("tp3_tmo", 32'(bus.timeout), 32'd1);
        check("tp3_regnt", 32'(bus.gnt), 32'h08);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h08, 1'b0);
        cycle(1'b1, 8'h08, 1'b1);
        check("tp3_done_no_tmo", 32'(bus.timeout), 32'd0);

        // Request drop advances the pointer past the dropped owner.
        do_reset();
        cycle(1'b1, 8'h20, 1'b0);
        check("tp4_g5", 32'(bus.gnt_idx), 32'd5);
        cycle(1'b1, 8'h00, 1'b0);
        check("tp4_clear", 32'(bus.gnt), 32'h00);
        cycle(1'b1, 8'h21, 1'b0);
        check("tp4_wrap0", 32'(bus.gnt), 32'h01);

        // en low does not abort an active grant but blocks new ones.
        do_reset();
        cycle(1'b1, 8'h04, 1'b0);
        cycle(1'b0, 8'hFF, 1'b0);
        check("tp5_persist", 32'(bus.gnt), 32'h04);
        cycle(1'b0, 8'hFF, 1'b1);
        cycle(1'b0, 8'hFF, 1'b0);
        check("tp5_idle", 32'(bus.gnt), 32'h00);
        cycle(1'b1, 8'hFF, 1'b0);
        check("tp5_next", 32'(bus.gnt_idx), 32'd3);

        // done while idle is ignored.
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check("idle_done", 32'(bus.gnt_vld), 32'd0);

        // Asynchronous reset mid-grant.
        do_reset();
        cycle(1'b1, 8'h10, 1'b0);
        check("tp6_pre", 32'(bus.gnt), 32'h10);
        do_reset();
        check("tp6_async", 32'(bus.gnt), 32'h00);
        cycle(1'b1, 8'h11, 1'b0);
        check("tp6_after", 32'(bus.gnt), 32'h01);

        // Random traffic with slowly varying requests.
        cur_req = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] flip;
            if ($urandom_range(0, 399) == 0) do_reset();
            flip = 8'h00;
            for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 9) == 0);
            cur_req = cur_req ^ flip;
            cycle($urandom_range(0, 9) != 0, cur_req, $urandom_range(0, 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
